systolic_feeder: RTL

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder_if.sv | 28 ++
 rtl/systolic_feeder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/systolic_feeder_if.sv
// Operand and array-side bus of the systolic feeder.
// master = operand source plus array observer, slave = the feeder itself.
interface systolic_feeder_if #(
  parameter int data_size = 8,
  parameter int N         = 4
);
  // Handshake: a beat transfers on a rising edge where in_valid and in_ready are both high.
  // in_ready may be low while in_valid is high; the source must then hold its beat stable.
  logic                      in_valid;
  logic                      in_ready;
  logic [N*data_size-1:0]    in_a;
  logic [N*data_size-1:0]    in_b;
  logic [N*data_size-1:0]    out_a;
  logic [N*data_size-1:0]    out_b;
  logic                      pe_clr;
  logic                      busy;
  logic                      done;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, out_a, out_b, pe_clr, busy, done
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, out_a, out_b, pe_clr, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers an N x N A/B operand pair and streams it skewed into an N x N systolic array.
// Optional macro SYSTOLIC_FEEDER_DBUF_EN adds a second bank so the next pair loads while one streams.
module systolic_feeder #(
  parameter int data_size = 8,
  parameter int N         = 4
) (
  input  logic             clk,
  input  logic             reset,
  systolic_feeder_if.slave bus,
  output logic [1:0]       dbg_state
);
  localparam int LW = N * data_size;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(2 * N + 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    CLR   = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [KW-1:0] beat_cnt;
  logic          wr_bank, feed_bank, wr_full;
  logic          accept, last_beat, launch, next_full;
  logic [LW-1:0] a_nx, b_nx;
  logic [LW-1:0] a_mem [2][N];
  logic [LW-1:0] b_mem [2][N];

`ifdef SYSTOLIC_FEEDER_DBUF_EN
  localparam logic DBUF = 1'b1;
  assign bus.in_ready = (state == FILL) || !wr_full;
`else
  localparam logic DBUF = 1'b0;
  assign bus.in_ready = (state == FILL);
`endif

  assign accept    = bus.in_valid && bus.in_ready;
  assign last_beat = (beat_cnt == KW'(N - 1));
  // A bank counts as full at the end of DRAIN even if its last beat lands on that very cycle.
  assign next_full = wr_full || (accept && last_beat);

  assign bus.busy  = (state != FILL);
  assign bus.done  = (state == DRAIN) && (cnt == CW'(N));
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    launch   = 1'b0;
    unique case (state)
      FILL: begin
        if (accept && last_beat) begin
          state_nx = CLR;
          launch   = 1'b1;
        end
      end
      CLR: begin
        state_nx = FEED;
        cnt_nx   = '0;
      end
      FEED: begin
        if (cnt == CW'(2 * N - 2)) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DRAIN: begin
        // cnt 0..N-1 flush the array, cnt == N is the done cycle.
        if (cnt == CW'(N)) begin
          cnt_nx = '0;
          if (next_full) begin
            state_nx = CLR;
            launch   = 1'b1;
          end else begin
            state_nx = FILL;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  // Lane l carries element k = t - l of the bank being fed, zero outside the skew window.
  always_comb begin
    int k;
    a_nx = '0;
    b_nx = '0;
    k    = 0;
    if (state_nx == FEED) begin
      for (int l = 0; l < N; l++) begin
        k = int'(cnt_nx) - l;
        if (k >= 0 && k < N) begin
          a_nx[l*data_size +: data_size] = a_mem[feed_bank][KW'(k)][l*data_size +: data_size];
          b_nx[l*data_size +: data_size] = b_mem[feed_bank][KW'(k)][l*data_size +: data_size];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FILL;
      cnt        <= '0;
      beat_cnt   <= '0;
      wr_bank    <= 1'b0;
      feed_bank  <= 1'b0;
      wr_full    <= 1'b0;
      bus.out_a  <= '0;
      bus.out_b  <= '0;
      bus.pe_clr <= 1'b1;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      bus.out_a  <= a_nx;
      bus.out_b  <= b_nx;
      bus.pe_clr <= (state_nx == CLR);
      if (launch) begin
        feed_bank <= wr_bank;
        wr_bank   <= wr_bank ^ DBUF;
        beat_cnt  <= '0;
        wr_full   <= 1'b0;
      end else if (accept) begin
        if (last_beat) begin
          beat_cnt <= '0;
          wr_full  <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

  // Operand storage carries no reset; beat_cnt and the FSM decide what is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_mem[wr_bank][beat_cnt] <= bus.in_a;
      b_mem[wr_bank][beat_cnt] <= bus.in_b;
    end
  end
endmodule
